// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, frame constants, receiver states.
// Pure declarations and a parity helper; no timing or flow control.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_EVEN = 2'b10;

    localparam int   FRAME_BITS = 11;
    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Bit the parity slot must carry; 11 falls back to "none" and is not checked.
    function automatic logic parity_expected(input logic [1:0] setting,
                                             input logic [DATA_BITS-1:0] data);
        parity_expected = (setting == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable down-counter that flags the cycle in which it sits at zero.
// Tick is combinational from the count; load takes priority over counting.
module uart_baud_tick #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             tick
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_value;
        end else if (enable && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign tick = enable && (r_cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, parity slot, stop; mid-bit sampling.
// Byte appears 1 cycle after the stop sample; a frame finishing while the host holds the word is dropped with rx_overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned MIN_DIVISOR = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_data,
    input  logic [1:0]  cfg_parity_setting,
    input  logic [31:0] cfg_clkSpeed_over_bdRate,
    output logic [7:0]  rx_data_word,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        rx_parity_error,
    output logic        rx_framing_error,
    output logic        rx_overrun,
    output logic        rx_busy
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    rx_state_t              r_state;
    rx_state_t              w_next;
    logic [31:0]            r_div;
    logic [1:0]             r_par_cfg;
    logic [2:0]             r_idx;
    logic [7:0]             r_shift;
    logic                   r_par_err;
    logic                   r_stop;
    logic                   r_done;

    logic        w_rx_s;
    logic        w_fall;
    logic [31:0] w_deff;
    logic        w_tick;
    logic        w_load;
    logic [31:0] w_load_val;
    logic        w_enable;

    assign w_rx_s  = r_sync[SYNC_STAGES-1];
    assign w_fall  = r_prev && !w_rx_s;
    assign w_deff  = (cfg_clkSpeed_over_bdRate < MIN_DIVISOR) ? 32'(MIN_DIVISOR)
                                                              : cfg_clkSpeed_over_bdRate;
    assign rx_busy = (r_state != IDLE);

    uart_baud_tick #(.WIDTH(32)) u_tick (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .load_value (w_load_val),
        .enable     (w_enable),
        .tick       (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = r_div - 32'd1;
        w_enable   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_next     = START;
                    w_load     = 1'b1;
                    w_load_val = w_deff >> 1;
                end
            end
            START: begin
                w_enable = 1'b1;
                if (w_tick) begin
                    if (!w_rx_s) begin
                        w_next = DATA;
                        w_load = 1'b1;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            DATA: begin
                w_enable = 1'b1;
                if (w_tick) begin
                    w_load = 1'b1;
                    if (r_idx == 3'(DATA_BITS - 1)) begin
                        w_next = PARITY;
                    end
                end
            end
            PARITY: begin
                w_enable = 1'b1;
                if (w_tick) begin
                    w_load = 1'b1;
                    w_next = STOP;
                end
            end
            STOP: begin
                w_enable = 1'b1;
                if (w_tick) begin
                    w_next = w_rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (w_rx_s) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync           <= {SYNC_STAGES{IDLE_LEVEL}};
            r_prev           <= IDLE_LEVEL;
            r_div            <= 32'(MIN_DIVISOR);
            r_par_cfg        <= PARITY_NONE;
            r_idx            <= '0;
            r_shift          <= '0;
            r_par_err        <= 1'b0;
            r_stop           <= 1'b1;
            r_done           <= 1'b0;
            rx_data_word     <= '0;
            rx_valid         <= 1'b0;
            rx_parity_error  <= 1'b0;
            rx_framing_error <= 1'b0;
            rx_overrun       <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], rx_data};
            r_prev     <= w_rx_s;
            r_done     <= 1'b0;
            rx_overrun <= 1'b0;

            // Frame config is frozen here so mid-frame cfg writes cannot skew sampling.
            if ((r_state == IDLE) && w_fall) begin
                r_div     <= w_deff;
                r_par_cfg <= cfg_parity_setting;
                r_idx     <= '0;
            end
            if ((r_state == DATA) && w_tick) begin
                r_shift[r_idx] <= w_rx_s;
                r_idx          <= r_idx + 3'd1;
            end
            if ((r_state == PARITY) && w_tick) begin
                r_par_err <= ((r_par_cfg == PARITY_ODD) || (r_par_cfg == PARITY_EVEN)) &&
                             (w_rx_s != parity_expected(r_par_cfg, r_shift));
            end
            if ((r_state == STOP) && w_tick) begin
                r_done <= 1'b1;
                r_stop <= w_rx_s;
            end

            if (rx_valid && rx_ready) begin
                rx_valid         <= 1'b0;
                rx_parity_error  <= 1'b0;
                rx_framing_error <= 1'b0;
            end
            // A same-cycle consume frees the holding register for the new frame.
            if (r_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data_word     <= r_shift;
                    rx_parity_error  <= r_par_err;
                    rx_framing_error <= !r_stop;
                    rx_valid         <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Standalone UART receiver; the receive-side counterpart of the existing UART transmitter.
- Deserialises one 11-bit frame on rx_data: start(0), data[7:0] LSB first, parity slot, stop(1).
- Samples each bit at mid-bit, using a cycle counter derived from cfg_clkSpeed_over_bdRate.
- Presents the byte plus parity/framing status to the host through a valid/ready register.

Parameters:
- SYNC_STAGES, 2, input synchroniser depth on rx_data (minimum 2).
- MIN_DIVISOR, 4, smallest divisor honoured; smaller cfg values are clamped up to this.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  1  serial line; idles high; asynchronous to clk.
- cfg_parity_setting  in  2  00 none, 01 odd, 10 even, 11 treated as none.
- cfg_clkSpeed_over_bdRate  in  32  clk cycles per bit (D).
- rx_data_word  out  8  received byte.
- rx_valid  out  1  rx_data_word and error flags hold a frame not yet consumed.
- rx_ready  in  1  host accepts the word when rx_valid && rx_ready.
- rx_parity_error  out  1  parity mismatch for the held frame.
- rx_framing_error  out  1  stop bit sampled as 0 for the held frame.
- rx_overrun  out  1  one-cycle pulse: a frame was dropped because rx_valid was still set.
- rx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (async, immediate): synchroniser stages = 1; state IDLE; rx_data_word = 0x00; rx_valid, both error flags, rx_overrun, rx_busy = 0.
- Divisor:
  - D_eff = max(cfg_clkSpeed_over_bdRate, MIN_DIVISOR).
  - D_eff, the parity setting and the half-bit value D_eff>>1 are latched when leaving IDLE.
  - cfg changes mid-frame have no effect on that frame.
- State IDLE:
  - Waits for a 1->0 transition on the synchronised line (synced low while the previous synced value was high).
  - On that transition: go to START and load the counter with half = D_eff>>1.
- State START:
  - Counter decrements every cycle; the sample happens in the cycle it reaches 0.
  - Sample 0: valid start. Go to DATA, bit index 0, reload the counter with D_eff-1.
  - Sample 1: false start (glitch). Return to IDLE with no flag and no output change.
- State DATA:
  - Each time the counter reaches 0, shift the sample into data[index] (LSB first) and reload D_eff-1.
  - After index 7, go to PARITY.
- State PARITY:
  - One sample, taken the same way.
  - Expected bit: odd = ~^data; even = ^data.
  - With setting 00 or 11 the sampled value is ignored and no parity error is possible.
- State STOP:
  - One sample at mid-bit.
  - Completion happens in the cycle after the stop sample:
    - If rx_valid = 0: load rx_data_word and both flags, set rx_valid, return to IDLE.
    - If rx_valid = 1 and rx_ready = 0 in that cycle: drop the new frame, pulse rx_overrun for 1 cycle, keep the held word.
    - If rx_valid = 1 and rx_ready = 1 in that cycle: the old word is consumed and the new word loads; no overrun.
  - Stop sampled 0: the frame still completes with rx_framing_error = 1, then go to BREAK instead of IDLE.
- State BREAK:
  - Waits for the synced line to be 1, then goes to IDLE.
  - Prevents a held-low line from being read as repeated frames.
- Handshake:
  - rx_valid clears on the cycle after rx_valid && rx_ready.
  - The error flags are valid only while rx_valid = 1 and clear together with it.
- Latency: about 2 synchroniser cycles + D_eff/2 + 10*D_eff from the start edge to the stop sample, then 1 cycle to rx_valid.
- Back-to-back frames: returning to IDLE right after the stop sample allows a next start edge half a bit later.
- Counter width: 32 bits; never wraps, because it is reloaded before underflow.
- rst asserted mid-frame aborts immediately; the partial byte is discarded.

Decomposition:
- Shared package uart_pkg:
  - Parity encodings PARITY_NONE=00, PARITY_ODD=01, PARITY_EVEN=10.
  - Constants FRAME_BITS=11, DATA_BITS=8, IDLE_LEVEL=1.
  - RX state enum {IDLE, START, DATA, PARITY, STOP, BREAK}.
- One sub-module, uart_baud_tick:
  - Inputs: load, load_value, enable.
  - Output: tick when the count reaches 0.
  - Also reusable by a rewritten transmitter.

Test Plan:
- D=16, even parity, send 0x55 with parity 0, stop 1 -> rx_valid with rx_data_word=0x55, both error flags 0; rx_valid drops 1 cycle after rx_ready.
- D=16, odd parity, send 0xA3 with parity 0 (expected 1) -> rx_data_word=0xA3, rx_parity_error=1, rx_framing_error=0.
- D=8, send 0x0F with stop 0, then hold the line low 5 bit times -> one frame: rx_data_word=0x0F, rx_framing_error=1; no further rx_valid until the line returns high and a new start arrives.
- D=16, low glitch of 3 cycles on an idle line -> no rx_valid; rx_busy high for at most 2 sync cycles + 8 cycles, then 0.
- Two frames 0x11 then 0x22 back-to-back, rx_ready held 0 -> rx_data_word stays 0x11; rx_overrun pulses exactly 1 cycle at the second completion.
- Assert rst during data bit 4 of 0xFF, release, then send 0x3C -> no output from the aborted frame; next rx_valid carries 0x3C.
- cfg_clkSpeed_over_bdRate=2 -> receiver runs at D=4; frame 0x81 received correctly.
